// File: rtl/data_sram_ctrl.sv
// -----------------------------------------------------------------------------
// data_sram_ctrl
// Sequences one load/store per instruction from the EX->MEM boundary onto a
// request/address-ok/data-ok data-SRAM bus. While the access is outstanding it
// asks the pipeline controller to stall. A completed load result is held until
// the MEM stage advances. A watchdog aborts accesses the bus never completes.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         EX presents a memory access this cycle
//   i_req_wen[3:0]      byte write enables (0 = load)
//   i_req_addr[31:0]    byte address ([1:0] not forwarded)
//   i_req_wdata[31:0]   store data, pre-aligned to byte lanes
//   i_advance           MEM stage consumes the held result this cycle
//   o_stallreq          freeze IF..EX while high
//   o_rdata[31:0]       held load result
//   o_rdata_valid       held load result is valid
//   o_timeout_err       sticky: an access was aborted by the watchdog
//   o_bus_req/_wr/_wstrb/_addr/_wdata   registered bus request fields
//   i_bus_addr_ok       bus accepted the request this cycle
//   i_bus_data_ok       read data / write response this cycle
//   i_bus_rdata[31:0]   read data, valid with i_bus_data_ok
// -----------------------------------------------------------------------------
module data_sram_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [3:0]  i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_advance,
  output logic        o_stallreq,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_timeout_err,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [3:0]  o_bus_wstrb,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_addr_ok,
  input  logic        i_bus_data_ok,
  input  logic [31:0] i_bus_rdata
);

  // Counter value at which an access that has not completed is aborted.
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_latch;
  logic        w_capture;
  logic        w_timeout;
  logic        w_stall;
  logic        w_expired;
  logic        w_is_load;

  logic        r_bus_req;
  logic        r_bus_wr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_timeout_err;
  logic [15:0] r_cnt;

  // Byte-offset bits are deliberately dropped; lane selection is via i_req_wen.
  logic        w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^i_req_addr[1:0];

  // Using >= so an access whose address handshake won the timeout cycle is
  // still aborted on the next cycle if its data never arrives.
  assign w_expired = (r_cnt >= LP_CNT_LAST);
  assign w_is_load = (r_bus_wstrb == 4'b0000);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-cycle control strobes for the datapath.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = i_req_valid;
        if (i_req_valid) begin
          w_latch      = 1'b1;
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (i_bus_addr_ok) begin
          w_next_state = S_WAIT;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (i_bus_data_ok) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE: begin
        // The held result is consumed only on advance; a new request waiting
        // here is taken in the same cycle so there is no idle bubble.
        if (i_advance && i_req_valid) begin
          w_latch      = 1'b1;
          w_next_state = S_REQ;
        end else if (i_advance) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request latch, watchdog counter, result capture and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_req     <= 1'b0;
      r_bus_wr      <= 1'b0;
      r_bus_wstrb   <= 4'b0000;
      r_bus_addr    <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= 16'd0;
    end else begin
      r_bus_req <= (w_next_state == S_REQ);

      if (w_latch) begin
        r_bus_wstrb <= i_req_wen;
        r_bus_wr    <= (i_req_wen != 4'b0000);
        r_bus_addr  <= {i_req_addr[31:2], 2'b00};
        r_bus_wdata <= i_req_wdata;
        r_cnt       <= 16'd0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end

      // Stores leave the previously held load result untouched.
      if (w_capture && w_is_load) begin
        r_rdata <= i_bus_rdata;
      end else if (w_timeout) begin
        r_rdata <= 32'd0;
      end else begin
        r_rdata <= r_rdata;
      end

      // No latch can coincide with entering DONE, so the current strobes
      // still describe the access that is completing.
      r_rdata_valid <= (w_next_state == S_DONE) && w_is_load;

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
    end
  end

  assign o_stallreq    = w_stall;
  assign o_bus_req     = r_bus_req;
  assign o_bus_wr      = r_bus_wr;
  assign o_bus_wstrb   = r_bus_wstrb;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Scoreboard bench for data_sram_ctrl: stimulus pushes expected bus requests
// and expected completions into queues; monitors pop and compare them.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic [3:0]  i_req_wen;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_advance;
  logic        o_stallreq;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_timeout_err;
  logic        o_bus_req;
  logic        o_bus_wr;
  logic [3:0]  o_bus_wstrb;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_addr_ok;
  logic        i_bus_data_ok;
  logic [31:0] i_bus_rdata;

  data_sram_ctrl #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_advance(i_advance),
    .o_stallreq(o_stallreq), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_timeout_err(o_timeout_err), .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr),
    .o_bus_wstrb(o_bus_wstrb), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_addr_ok(i_bus_addr_ok), .i_bus_data_ok(i_bus_data_ok), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          ncyc;
  } req_t;

  typedef struct {
    int          stall;
    logic [31:0] rdata;
    logic        valid;
    logic        err;
  } done_t;

  req_t        exp_req_q[$];
  done_t       exp_done_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int failures = 0;

  // bus responder controls
  logic bus_auto = 1'b1;
  logic never_ack = 1'b0;
  int   addr_delay = 0;
  int   data_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus model: acks the address after addr_delay extra REQ cycles, then
  // returns data after data_delay extra WAIT cycles.
  initial begin : responder
    int   req_k;
    int   wait_j;
    logic wait_ph;
    req_k = 0; wait_j = 0; wait_ph = 1'b0;
    i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b0; i_bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_auto) begin
        i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b0; i_bus_rdata = 32'd0;
        if (o_bus_req) begin
          if (!never_ack && (req_k == addr_delay)) begin
            i_bus_addr_ok = 1'b1; wait_ph = 1'b1; wait_j = 0; req_k = 0;
          end else begin
            req_k++;
          end
        end else if (wait_ph) begin
          if (wait_j == data_delay) begin
            i_bus_data_ok = 1'b1;
            i_bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
            wait_ph = 1'b0;
          end else begin
            wait_j++;
          end
        end else begin
          req_k = 0;
        end
      end
    end
  end

  // Request monitor: checks every REQ cycle's fields and the REQ length.
  initial begin : req_mon
    req_t cur;
    logic in_req;
    int   ncyc;
    in_req = 1'b0; ncyc = 0;
    cur = '{addr: 32'd0, wr: 1'b0, wstrb: 4'd0, wdata: 32'd0, ncyc: 0};
    forever begin
      @(negedge clk);
      if (o_bus_req) begin
        if (!in_req) begin
          in_req = 1'b1; ncyc = 0;
          if (exp_req_q.size() == 0) begin
            chk("unexpected_bus_req", 32'd1, 32'd0);
          end else begin
            cur = exp_req_q.pop_front();
          end
        end
        ncyc++;
        chk("bus_addr", o_bus_addr, cur.addr);
        chk("bus_wr", {31'd0, o_bus_wr}, {31'd0, cur.wr});
        chk("bus_wstrb", {28'd0, o_bus_wstrb}, {28'd0, cur.wstrb});
        chk("bus_wdata", o_bus_wdata, cur.wdata);
      end else if (in_req) begin
        in_req = 1'b0;
        chk("bus_req_cycles", ncyc, cur.ncyc);
      end
    end
  end

  // Completion monitor: when stall drops, checks stall length and result.
  initial begin : done_mon
    int    run;
    done_t d;
    run = 0;
    forever begin
      @(negedge clk);
      if (o_stallreq) begin
        run++;
      end else if (run > 0) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          d = exp_done_q.pop_front();
          chk("stall_cycles", run, d.stall);
          chk("rdata", o_rdata, d.rdata);
          chk("rdata_valid", {31'd0, o_rdata_valid}, {31'd0, d.valid});
          chk("timeout_err", {31'd0, o_timeout_err}, {31'd0, d.err});
        end
        run = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr; i_req_wdata = wdata;
    @(posedge clk); #2;
    i_req_valid = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with stall low.
  task automatic wait_done(input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!o_stallreq) return;
    end
    chk({name, "_wait_expired"}, 32'd1, 32'd0);
  endtask

  task automatic do_advance();
    #1 i_advance = 1'b1;
    @(posedge clk); #2;
    i_advance = 1'b0;
  endtask

  task automatic push_req(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata, input int n);
    exp_req_q.push_back('{addr: addr, wr: (wen != 4'd0), wstrb: wen, wdata: wdata, ncyc: n});
  endtask

  task automatic push_done(input int st, input logic [31:0] rd, input logic v, input logic e);
    exp_done_q.push_back('{stall: st, rdata: rd, valid: v, err: e});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_wen = 4'd0; i_req_addr = 32'd0;
    i_req_wdata = 32'd0; i_advance = 1'b0;
    repeat (3) @(posedge clk);
    #2 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_stallreq", {31'd0, o_stallreq}, 32'd0);
    chk("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("rst_bus_addr", o_bus_addr, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_rdata_valid", {31'd0, o_rdata_valid}, 32'd0);
    chk("rst_timeout_err", {31'd0, o_timeout_err}, 32'd0);
    @(posedge clk); #2;

    // Load, zero-wait bus
    addr_delay = 0; data_delay = 0;
    rd_q.push_back(32'hA5A5_1234);
    push_req(32'h1000_0004, 4'b0000, 32'd0, 1);
    push_done(3, 32'hA5A5_1234, 1'b1, 1'b0);
    issue(4'b0000, 32'h1000_0006, 32'd0);
    wait_done("load0");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("load0_hold_valid", {31'd0, o_rdata_valid}, 32'd1);
      chk("load0_hold_rdata", o_rdata, 32'hA5A5_1234);
    end
    do_advance();

    // Store, addr_ok after 2 extra cycles, data_ok after 2 extra WAIT cycles
    addr_delay = 2; data_delay = 2;
    rd_q.push_back(32'h1234_5678);
    push_req(32'h2000_0010, 4'b1100, 32'hDEAD_0000, 3);
    push_done(7, 32'hA5A5_1234, 1'b0, 1'b0);
    issue(4'b1100, 32'h2000_0013, 32'hDEAD_0000);
    wait_done("store");
    do_advance();

    // Back-to-back loads
    addr_delay = 0; data_delay = 0;
    rd_q.push_back(32'h1111_1111);
    rd_q.push_back(32'h2222_2222);
    push_req(32'h0000_0100, 4'b0000, 32'd0, 1);
    push_done(3, 32'h1111_1111, 1'b1, 1'b0);
    issue(4'b0000, 32'h0000_0100, 32'd0);
    wait_done("b2b_a");
    push_req(32'h0000_0204, 4'b0000, 32'd0, 1);
    push_done(2, 32'h2222_2222, 1'b1, 1'b0);
    #1;
    i_req_valid = 1'b1; i_req_wen = 4'b0000; i_req_addr = 32'h0000_0204;
    i_req_wdata = 32'd0; i_advance = 1'b1;
    @(posedge clk); #2;
    i_req_valid = 1'b0; i_advance = 1'b0;
    @(negedge clk);
    chk("b2b_no_bubble_bus_req", {31'd0, o_bus_req}, 32'd1);
    wait_done("b2b_b");

    // DONE held for 4 cycles with a pending request and advance low
    #1;
    i_req_valid = 1'b1; i_req_wen = 4'b0011; i_req_addr = 32'h3000_0000;
    i_req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_rdata", o_rdata, 32'h2222_2222);
      chk("hold_bus_req", {31'd0, o_bus_req}, 32'd0);
      chk("hold_stallreq", {31'd0, o_stallreq}, 32'd0);
    end
    #1 i_req_valid = 1'b0;
    do_advance();

    // Timeout: addr_ok never arrives
    never_ack = 1'b1;
    push_req(32'h4000_0008, 4'b0000, 32'd0, 8);
    push_done(9, 32'd0, 1'b1, 1'b1);
    issue(4'b0000, 32'h4000_0008, 32'd0);
    wait_done("timeout");
    do_advance();
    never_ack = 1'b0;

    // Error stays sticky across a later normal load
    rd_q.push_back(32'h5555_AAAA);
    push_req(32'h5000_0000, 4'b0000, 32'd0, 1);
    push_done(3, 32'h5555_AAAA, 1'b1, 1'b1);
    issue(4'b0000, 32'h5000_0000, 32'd0);
    wait_done("sticky");
    do_advance();

    // Reset during WAIT, late data_ok afterwards
    bus_auto = 1'b0;
    push_req(32'h6000_0004, 4'b0000, 32'd0, 1);
    push_done(3, 32'd0, 1'b0, 1'b0);
    issue(4'b0000, 32'h6000_0004, 32'd0);
    @(negedge clk);
    i_bus_addr_ok = 1'b1;
    @(posedge clk); #2;
    i_bus_addr_ok = 1'b0;
    i_rst = 1'b1;
    @(posedge clk); #2;
    i_rst = 1'b0;
    i_bus_data_ok = 1'b1; i_bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rstw_bus_req", {31'd0, o_bus_req}, 32'd0);
    chk("rstw_bus_wr", {31'd0, o_bus_wr}, 32'd0);
    chk("rstw_bus_wstrb", {28'd0, o_bus_wstrb}, 32'd0);
    chk("rstw_bus_addr", o_bus_addr, 32'd0);
    chk("rstw_bus_wdata", o_bus_wdata, 32'd0);
    chk("rstw_timeout_err", {31'd0, o_timeout_err}, 32'd0);
    @(posedge clk); #2;
    i_bus_data_ok = 1'b0; i_bus_rdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstw_rdata", o_rdata, 32'd0);
      chk("rstw_rdata_valid", {31'd0, o_rdata_valid}, 32'd0);
      chk("rstw_stallreq", {31'd0, o_stallreq}, 32'd0);
    end
    bus_auto = 1'b1;

    repeat (3) @(negedge clk);
    chk("req_queue_drained", exp_req_q.size(), 32'd0);
    chk("done_queue_drained", exp_done_q.size(), 32'd0);
    chk("rd_queue_drained", rd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
